io_bus_responder: RTL and testbench

- Responder (peripheral) end of the CPU IO_BUS: decodes io_addr/io_we/io_rd from the CPU and returns read data on io_din.
- Provides a memory-mapped LED register, a switch-input channel with valid handshake, a display-output channel with ready handshake, and an overrun counter.
- Sits beside the CPU in the top level. CPU debug-bus logic is out of scope.

---
 rtl/io_bus_pkg.sv | 22 ++
 rtl/btn_debounce_edge.sv | 46 ++++
 rtl/io_bus_responder.sv | 129 ++++++++++++
 tb/tb_io_bus_responder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// io_bus_pkg: word addresses of the responder's register map, plus word-address helper.
// Revision 1.0
`default_nettype none

package io_bus_pkg;

  localparam logic [7:0] ADDR_LED        = 8'h00;
  localparam logic [7:0] ADDR_IN_STATUS  = 8'h04;
  localparam logic [7:0] ADDR_IN_DATA    = 8'h08;
  localparam logic [7:0] ADDR_OUT_STATUS = 8'h0C;
  localparam logic [7:0] ADDR_OUT_DATA   = 8'h10;
  localparam logic [7:0] ADDR_SW         = 8'h14;
  localparam logic [7:0] ADDR_OVR_CNT    = 8'h18;

  // Byte offset within the word is not decoded.
  function automatic logic [7:0] word_addr(input logic [7:0] addr);
    return {addr[7:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce_edge.sv
// btn_debounce_edge: 2-flop synchroniser, counter debounce and rising-edge pulse for one button.
// Revision 1.0
`default_nettype none

module btn_debounce_edge #(
  parameter int unsigned          CNT_W           = 16,
  parameter logic [CNT_W-1:0]     DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn,
  output logic pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1'b1);

  logic [1:0]       sync_q;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= 2'b00;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      level_d <= level;
      if (sync_q[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync_q[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign pulse = level & ~level_d;

endmodule

`default_nettype wire

// File: rtl/io_bus_responder.sv
// io_bus_responder: IO_BUS peripheral with LED register, switch-input and display-output
// handshake channels and a saturating input-overrun counter. Revision 1.0
`default_nettype none

module io_bus_responder
  import io_bus_pkg::*;
#(
  parameter int unsigned      CNT_W           = 16,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  input  logic        io_rd,
  output logic [31:0] io_din,
  input  logic [15:0] sw,
  input  logic        btn_in,
  input  logic        btn_out,
  output logic [15:0] out_led,
  output logic [31:0] out_seg,
  output logic        in_vld_led,
  output logic        out_vld_led
);

  logic [15:0] sw_meta;
  logic [15:0] sw_sync;
  logic [15:0] in_data;
  logic        in_vld;
  logic        out_vld;
  logic [7:0]  ovr_cnt;
  logic        in_pulse;
  logic        out_pulse;

  logic [7:0]  word;
  logic        wr_led;
  logic        wr_out;
  logic        wr_ovr;
  logic        rd_in_data;

  btn_debounce_edge #(
    .CNT_W           (CNT_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_in (
    .clk   (clk),
    .rstn  (rstn),
    .btn   (btn_in),
    .pulse (in_pulse)
  );

  btn_debounce_edge #(
    .CNT_W           (CNT_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_out (
    .clk   (clk),
    .rstn  (rstn),
    .btn   (btn_out),
    .pulse (out_pulse)
  );

  assign word       = word_addr(io_addr);
  assign wr_led     = io_we && (word == ADDR_LED);
  assign wr_out     = io_we && (word == ADDR_OUT_DATA);
  assign wr_ovr     = io_we && (word == ADDR_OVR_CNT);
  assign rd_in_data = io_rd && (word == ADDR_IN_DATA);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sw_meta <= '0;
      sw_sync <= '0;
      out_led <= '0;
      out_seg <= '0;
      in_data <= '0;
      in_vld  <= 1'b0;
      out_vld <= 1'b0;
      ovr_cnt <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;

      if (wr_led) begin
        out_led <= io_dout[15:0];
      end

      // A capture coinciding with the read-clear refills the slot instead of overrunning.
      if (in_pulse && (!in_vld || rd_in_data)) begin
        in_data <= sw_sync;
        in_vld  <= 1'b1;
      end else if (in_pulse) begin
        if (ovr_cnt != 8'hFF) begin
          ovr_cnt <= ovr_cnt + 1'b1;
        end
      end else if (rd_in_data) begin
        in_vld <= 1'b0;
      end

      if (wr_ovr) begin
        ovr_cnt <= '0;
      end

      if (wr_out && !out_vld) begin
        out_seg <= io_dout;
        out_vld <= 1'b1;
      end else if (out_pulse) begin
        out_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    io_din = 32'h0;
    case (word)
      ADDR_LED:        io_din = {16'h0, out_led};
      ADDR_IN_STATUS:  io_din = {31'h0, in_vld};
      ADDR_IN_DATA:    io_din = {16'h0, in_data};
      ADDR_OUT_STATUS: io_din = {31'h0, ~out_vld};
      ADDR_SW:         io_din = {16'h0, sw_sync};
      ADDR_OVR_CNT:    io_din = {24'h0, ovr_cnt};
      default:         io_din = 32'h0;
    endcase
  end

  assign in_vld_led  = in_vld;
  assign out_vld_led = out_vld;

endmodule

`default_nettype wire

// File: tb/tb_io_bus_responder.sv
// tb_io_bus_responder: directed scenarios plus random bus traffic against a register-level model.
// Revision 1.0
`default_nettype none

module tb_io_bus_responder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  io_addr = 8'h00;
  logic [31:0] io_dout = 32'h0;
  logic        io_we = 1'b0;
  logic        io_rd = 1'b0;
  logic [31:0] io_din;
  logic [15:0] sw = 16'h0;
  logic        btn_in = 1'b0;
  logic        btn_out = 1'b0;
  logic [15:0] out_led;
  logic [31:0] out_seg;
  logic        in_vld_led;
  logic        out_vld_led;

  io_bus_responder #(
    .CNT_W           (16),
    .DEBOUNCE_CYCLES (16'd4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .io_addr     (io_addr),
    .io_dout     (io_dout),
    .io_we       (io_we),
    .io_rd       (io_rd),
    .io_din      (io_din),
    .sw          (sw),
    .btn_in      (btn_in),
    .btn_out     (btn_out),
    .out_led     (out_led),
    .out_seg     (out_seg),
    .in_vld_led  (in_vld_led),
    .out_vld_led (out_vld_led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  int fails = 0;
  int in_pe = -1;   // edge number at which a debounced in-button pulse takes effect
  int out_pe = -1;

  logic [15:0] m_led, m_in_data, m_sw1, m_sw2;
  logic [31:0] m_seg;
  logic        m_in_vld, m_out_vld;
  logic [7:0]  m_ovr;

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a & 8'hFC)
      8'h00:   return {16'h0, m_led};
      8'h04:   return {31'h0, m_in_vld};
      8'h08:   return {16'h0, m_in_data};
      8'h0C:   return {31'h0, ~m_out_vld};
      8'h14:   return {16'h0, m_sw2};
      8'h18:   return {24'h0, m_ovr};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_led = '0; m_in_data = '0; m_sw1 = '0; m_sw2 = '0;
    m_seg = '0; m_in_vld = 1'b0; m_out_vld = 1'b0; m_ovr = '0;
    in_pe = -1; out_pe = -1;
  endtask

  task automatic model_edge();
    logic [7:0] w;
    logic in_p, out_p, rdclr;
    w     = io_addr & 8'hFC;
    in_p  = (cyc == in_pe);
    out_p = (cyc == out_pe);
    rdclr = io_rd && (w == 8'h08);
    if (io_we && w == 8'h00) m_led = io_dout[15:0];
    if (in_p && (!m_in_vld || rdclr)) begin
      m_in_data = m_sw2;
      m_in_vld  = 1'b1;
    end else if (in_p) begin
      m_ovr = (m_ovr == 8'hFF) ? 8'hFF : 8'(m_ovr + 8'd1);
    end else if (rdclr) begin
      m_in_vld = 1'b0;
    end
    if (io_we && w == 8'h18) m_ovr = 8'h00;
    if (io_we && w == 8'h10 && !m_out_vld) begin
      m_seg     = io_dout;
      m_out_vld = 1'b1;
    end else if (out_p) begin
      m_out_vld = 1'b0;
    end
    m_sw2 = m_sw1;
    m_sw1 = sw;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("io_din",      io_din,                model_read(io_addr));
    chk("out_led",     {16'h0, out_led},      {16'h0, m_led});
    chk("out_seg",     out_seg,               m_seg);
    chk("in_vld_led",  {31'h0, in_vld_led},   {31'h0, m_in_vld});
    chk("out_vld_led", {31'h0, out_vld_led},  {31'h0, m_out_vld});
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (rstn) model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    io_we = 1'b0;
    io_rd = 1'b0;
    repeat (n) step();
  endtask

  task automatic rand_steps(input int n);
    repeat (n) begin
      io_addr = 8'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
      io_we   = ($urandom_range(0, 3) == 0);
      io_rd   = 1'($urandom_range(0, 1));
      io_dout = $urandom;
      sw      = 16'($urandom);
      step();
    end
    io_we = 1'b0;
    io_rd = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    io_addr = a;
    io_dout = d;
    io_we   = 1'b1;
    step();
    io_we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
    io_addr = a;
    io_rd   = 1'b1;
    #1;
    chk(tag, io_din, exp);
    step();
    io_rd = 1'b0;
  endtask

  // Clean press: 10 cycles high, 8 low; the pulse acts on the 7th edge after the raw edge.
  task automatic press(input bit bi, input bit bo, input bit rnd);
    if (bi) begin btn_in = 1'b1;  in_pe  = cyc + 7; end
    if (bo) begin btn_out = 1'b1; out_pe = cyc + 7; end
    if (rnd) rand_steps(10); else idle(10);
    btn_in  = 1'b0;
    btn_out = 1'b0;
    if (rnd) rand_steps(8); else idle(8);
  endtask

  initial begin
    model_reset();
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    idle(1);

    // Register map after reset
    for (int a = 0; a <= 8'h18; a += 4)
      bus_read(8'(a), (a == 8'h0C) ? 32'd1 : 32'd0, "t1_reset_read");

    // Input capture latency and read-clear
    sw = 16'hA5C3;
    idle(2);
    btn_in = 1'b1;
    in_pe  = cyc + 7;
    idle(6);
    chk("t2_vld_before_7", {31'h0, in_vld_led}, 32'd0);
    idle(1);
    chk("t2_vld_at_7", {31'h0, in_vld_led}, 32'd1);
    idle(3);
    btn_in = 1'b0;
    idle(8);
    bus_read(8'h08, 32'h0000A5C3, "t2_in_data");
    chk("t2_vld_cleared", {31'h0, in_vld_led}, 32'd0);

    // Bounce rejection, then overrun
    btn_in = 1'b1; idle(1);
    btn_in = 1'b0; idle(1);
    btn_in = 1'b1; idle(1);
    btn_in = 1'b0; idle(10);
    chk("t3_no_pulse", {31'h0, in_vld_led}, 32'd0);
    sw = 16'h1111; idle(2);
    press(1'b1, 1'b0, 1'b0);
    sw = 16'h2222; idle(2);
    press(1'b1, 1'b0, 1'b0);
    bus_read(8'h18, 32'd1, "t3_ovr_cnt");
    bus_read(8'h08, 32'h00001111, "t3_data_held");

    // Output channel
    bus_write(8'h10, 32'h12345678);
    chk("t4_seg", out_seg, 32'h12345678);
    bus_read(8'h0C, 32'd0, "t4_busy");
    bus_write(8'h10, 32'hDEADBEEF);
    chk("t4_seg_dropped", out_seg, 32'h12345678);
    press(1'b0, 1'b1, 1'b0);
    bus_read(8'h0C, 32'd1, "t4_ready");
    chk("t4_seg_hold", out_seg, 32'h12345678);

    // Same-cycle read-clear with capture
    sw = 16'h3333; idle(2);
    press(1'b1, 1'b0, 1'b0);
    sw = 16'h0F0F; idle(2);
    btn_in = 1'b1;
    in_pe  = cyc + 7;
    idle(6);
    io_addr = 8'h08;
    io_rd   = 1'b1;
    step();
    io_rd = 1'b0;
    chk("t5_vld_kept", {31'h0, in_vld_led}, 32'd1);
    idle(3);
    btn_in = 1'b0;
    idle(8);
    bus_read(8'h08, 32'h00000F0F, "t5_data");
    bus_read(8'h18, 32'd1, "t5_no_overrun");

    // Same-cycle write with out_pulse while full
    bus_write(8'h10, 32'hCAFE0001);
    btn_out = 1'b1;
    out_pe  = cyc + 7;
    idle(6);
    io_addr = 8'h10;
    io_dout = 32'h00000BAD;
    io_we   = 1'b1;
    step();
    io_we = 1'b0;
    chk("t5_out_vld_clr", {31'h0, out_vld_led}, 32'd0);
    chk("t5_seg_kept", out_seg, 32'hCAFE0001);
    idle(3);
    btn_out = 1'b0;
    idle(8);

    // Asynchronous reset mid-debounce
    bus_write(8'h00, 32'h0000FFFF);
    bus_write(8'h10, 32'h5555AAAA);
    btn_in = 1'b1;
    in_pe  = cyc + 7;
    idle(3);
    io_addr = 8'h00;
    #2;
    rstn   = 1'b0;
    btn_in = 1'b0;
    #1;
    chk("t6_led", {16'h0, out_led}, 32'h0);
    chk("t6_seg", out_seg, 32'h0);
    chk("t6_in_vld", {31'h0, in_vld_led}, 32'd0);
    chk("t6_out_vld", {31'h0, out_vld_led}, 32'd0);
    chk("t6_io_din", io_din, 32'h0);
    model_reset();
    idle(2);
    rstn = 1'b1;
    idle(12);
    chk("t6_no_pulse", {31'h0, in_vld_led}, 32'd0);

    // Overrun saturation and clear
    repeat (257) press(1'b1, 1'b0, 1'b0);
    bus_read(8'h18, 32'h000000FF, "sat_ovr");
    bus_write(8'h18, 32'h12345678);
    bus_read(8'h18, 32'h0, "ovr_clear");

    // Random bus traffic mixed with button presses
    repeat (20) begin
      press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      rand_steps(30);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
